// File: rtl/write_buffer.sv
// write_buffer -- posted-write FIFO between a write-through cache and main memory.
//
// Cache writes are absorbed into a DEPTH-entry FIFO and complete one cycle after
// acceptance. The FIFO drains to memory in order. A read waits until every older
// write has reached memory, then goes to memory itself. This keeps
// read-after-write coherent.
//
// Optional feature (macro WRITE_BUFFER_FWD_EN): a read whose word address
// (addr[AW-1:2]) matches a buffered write is answered directly from the youngest
// matching entry, one cycle after accept, without a memory access.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-low reset (0 = reset)
//   up_req     cache request, sampled only while up_ready=1
//   up_we      1 = write, 0 = read
//   up_addr    byte address
//   up_wdata   write data
//   up_ready   buffer can accept a request this cycle
//   up_done    one-cycle completion pulse
//   up_rdata   read data, valid while up_done=1
//   mem_req    memory request pulse
//   mem_we     memory write enable
//   mem_addr   memory address, held from mem_req until mem_done
//   mem_wdata  memory write data, held from mem_req until mem_done
//   mem_ready  memory idle and able to accept
//   mem_done   memory completion pulse
//   mem_rdata  memory read data, valid with mem_done
//   occupancy  number of buffered writes
//   empty      occupancy == 0
module write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up_req,
  input  logic                     up_we,
  input  logic [AW-1:0]            up_addr,
  input  logic [DW-1:0]            up_wdata,
  output logic                     up_ready,
  output logic                     up_done,
  output logic [DW-1:0]            up_rdata,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_ready,
  input  logic                     mem_done,
  input  logic [DW-1:0]            mem_rdata,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {D_IDLE, D_WAIT} d_state_t;
  typedef enum logic [2:0] {R_IDLE, R_DRAIN, R_ISSUE, R_WAIT, R_RESP} r_state_t;

  d_state_t d_state, d_next;
  r_state_t r_state, r_next;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [AW-1:0] r_addr;

  logic          full;
  logic          wr_acc, rd_acc;
  logic          drain_issue, drain_pop;
  logic          read_issue, read_cap;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign occupancy = count;
  // Registered state only: up_req never feeds back into up_ready.
  assign up_ready  = !full && (r_state == R_IDLE);
  assign wr_acc    = up_req &  up_we & up_ready;
  assign rd_acc    = up_req & ~up_we & up_ready;

`ifdef WRITE_BUFFER_FWD_EN
  logic [PW-1:0] idx;
  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_q[idx][AW-1:2] == up_addr[AW-1:2])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    d_next      = d_state;
    drain_issue = 1'b0;
    drain_pop   = 1'b0;
    case (d_state)
      D_IDLE: if (!empty && mem_ready) begin
        drain_issue = 1'b1;
        d_next      = D_WAIT;
      end
      D_WAIT: if (mem_done) begin
        drain_pop = 1'b1;
        d_next    = D_IDLE;
      end
      default: d_next = D_IDLE;
    endcase
  end

  // Reads only reach R_ISSUE once the FIFO is empty and the drain engine is
  // idle. No write can be accepted outside R_IDLE, so the memory port is never
  // contended.
  always_comb begin
    r_next     = r_state;
    read_issue = 1'b0;
    read_cap   = 1'b0;
    case (r_state)
      R_IDLE:  if (rd_acc) r_next = fwd_hit ? R_RESP : R_DRAIN;
      R_DRAIN: if (empty && (d_state == D_IDLE)) r_next = R_ISSUE;
      R_ISSUE: if (mem_ready) begin
        read_issue = 1'b1;
        r_next     = R_WAIT;
      end
      R_WAIT:  if (mem_done) begin
        read_cap = 1'b1;
        r_next   = R_RESP;
      end
      R_RESP:  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_state   <= D_IDLE;
      r_state   <= R_IDLE;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      up_done   <= 1'b0;
      up_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      d_state <= d_next;
      r_state <= r_next;
      if (wr_acc)    tail <= tail + 1'b1;
      if (drain_pop) head <= head + 1'b1;
      case ({wr_acc, drain_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // The read FSM sits in R_RESP for exactly the cycle this pulse is high.
      up_done <= wr_acc | read_cap | (rd_acc & fwd_hit);
      if (read_cap)
        up_rdata <= mem_rdata;
      else if (rd_acc && fwd_hit)
        up_rdata <= fwd_data;
      mem_req <= drain_issue | read_issue;
      if (drain_issue) begin
        mem_we    <= 1'b1;
        mem_addr  <= addr_q[head];
        mem_wdata <= data_q[head];
      end else if (read_issue) begin
        mem_we   <= 1'b0;
        mem_addr <= r_addr;
      end else if (drain_pop) begin
        mem_we <= 1'b0;
      end
    end
  end

  // FIFO storage and the latched read address carry no reset; their validity
  // is tracked by count and by the read FSM.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      addr_q[tail] <= up_addr;
      data_q[tail] <= up_wdata;
    end
    if (rd_acc) r_addr <= up_addr;
  end

endmodule

// File: tb/tb_write_buffer.sv
module tb_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 up_req = 1'b0, up_we = 1'b0;
  logic [AW-1:0]        up_addr = '0;
  logic [DW-1:0]        up_wdata = '0;
  logic                 up_ready, up_done;
  logic [DW-1:0]        up_rdata;
  logic                 mem_req, mem_we;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic                 mem_ready = 1'b1, mem_done = 1'b0;
  logic [DW-1:0]        mem_rdata = '0;
  logic [$clog2(DEPTH):0] occupancy;
  logic                 empty;

  always #5 clk = ~clk;

  write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .up_req(up_req), .up_we(up_we), .up_addr(up_addr), .up_wdata(up_wdata),
    .up_ready(up_ready), .up_done(up_done), .up_rdata(up_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .occupancy(occupancy), .empty(empty)
  );

  int checks = 0;
  int errors = 0;

  // Reference: memory contents as the cache should observe them (program order)
  logic [DW-1:0] ref_mem [int];
  // Memory model contents
  logic [DW-1:0] mem_arr [int];
  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  wr_t exp_wq[$];

  int  n_wr = 0, n_rd = 0, lat_fix = 0, wq_at_read = 0;
  bit  stall = 1'b0, busy = 1'b0, skip_hold = 1'b0;
  logic [AW-1:0] last_rd_addr = '0, last_wr_a = '0;
  logic [DW-1:0] last_wr_d = '0;

  function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
    return {16'hC0DE, a};
  endfunction

  function automatic logic [DW-1:0] ref_val(input logic [AW-1:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return mem_init(a);
  endfunction

  // Memory responder: accepts one request at a time, answers after a latency.
  initial begin
    int cnt;
    logic p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    wr_t e;
    cnt = 0; p_we = 1'b0; p_addr = '0; p_data = '0;
    forever begin
      @(negedge clk);
      mem_done = 1'b0;
      if (busy) begin
        if (rst && !skip_hold) begin
          checks++;
          if (mem_addr !== p_addr) begin
            errors++;
            $display("FAIL mem_addr_hold got=%h want=%h", mem_addr, p_addr);
          end
        end
        if (cnt == 0) begin
          mem_done = 1'b1;
          busy = 1'b0;
          if (p_we) mem_arr[int'(p_addr)] = p_data;
          else mem_rdata = mem_arr.exists(int'(p_addr)) ? mem_arr[int'(p_addr)] : mem_init(p_addr);
        end else cnt--;
      end else if (mem_req) begin
        busy = 1'b1; p_we = mem_we; p_addr = mem_addr; p_data = mem_wdata;
        cnt = (lat_fix != 0) ? lat_fix : int'($urandom_range(0, 2));
        if (mem_we) begin
          n_wr++; last_wr_a = mem_addr; last_wr_d = mem_wdata;
          checks++;
          if (exp_wq.size() == 0) begin
            errors++;
            $display("FAIL mem_write_unexpected got=%h:%h want=none", mem_addr, mem_wdata);
          end else begin
            e = exp_wq.pop_front();
            if (e.a !== mem_addr || e.d !== mem_wdata) begin
              errors++;
              $display("FAIL mem_write_order got=%h:%h want=%h:%h", mem_addr, mem_wdata, e.a, e.d);
            end
          end
        end else begin
          n_rd++; last_rd_addr = mem_addr; wq_at_read = exp_wq.size();
        end
      end else if (mem_req && busy) begin
        checks++; errors++;
        $display("FAIL mem_req_while_busy got=1 want=0");
      end
      mem_ready = !stall && !busy;
    end
  end

  // One cache request; lat = cycles from drive to up_done (-1 on timeout)
  task automatic xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output int lat, output logic [DW-1:0] rd);
    int w;
    w = 0; lat = -1; rd = '0;
    while (!up_ready && w < 300) begin @(negedge clk); w++; end
    if (!up_ready) return;
    up_req = 1'b1; up_we = we; up_addr = a; up_wdata = d;
    if (we) begin
      ref_mem[int'(a)] = d;
      exp_wq.push_back({a, d});
    end
    @(negedge clk);
    up_req = 1'b0; up_we = 1'b0;
    w = 1;
    while (!up_done && w < 300) begin @(negedge clk); w++; end
    if (up_done) begin lat = w; rd = up_rdata; end
  endtask

  task automatic wait_idle(output bit ok);
    int w;
    w = 0;
    while ((!empty || busy || !up_ready) && w < 500) begin @(negedge clk); w++; end
    ok = empty && !busy && up_ready;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks += 6;
    if (up_done !== 1'b0)   begin errors++; $display("FAIL rst_up_done got=%b want=0", up_done); end
    if (up_rdata !== '0)    begin errors++; $display("FAIL rst_up_rdata got=%h want=0", up_rdata); end
    if (mem_req !== 1'b0)   begin errors++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
    if (mem_we !== 1'b0)    begin errors++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
    if (mem_addr !== '0 || mem_wdata !== '0) begin errors++; $display("FAIL rst_mem_bus got=%h:%h want=0:0", mem_addr, mem_wdata); end
    if (occupancy !== '0 || empty !== 1'b1) begin errors++; $display("FAIL rst_occ got=%0d/%b want=0/1", occupancy, empty); end
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (up_ready !== 1'b1)  begin errors++; $display("FAIL rel_up_ready got=%b want=1", up_ready); end
    if (empty !== 1'b1 || mem_req !== 1'b0 || up_done !== 1'b0) begin
      errors++; $display("FAIL rel_state got=%b%b%b want=100", empty, mem_req, up_done);
    end
  endtask

  task automatic test_single_write;
    int lat, w0; logic [DW-1:0] rd; bit ok;
    w0 = n_wr;
    xfer(1'b1, 16'h1004, 32'hDEADBEEF, lat, rd);
    checks += 2;
    if (lat != 1) begin errors++; $display("FAIL sw_latency got=%0d want=1", lat); end
    if (occupancy !== 1) begin errors++; $display("FAIL sw_occ got=%0d want=1", occupancy); end
    wait_idle(ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL sw_drain_timeout got=0 want=1"); end
    if (n_wr - w0 != 1) begin errors++; $display("FAIL sw_count got=%0d want=1", n_wr - w0); end
    if (last_wr_a !== 16'h1004 || last_wr_d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL sw_payload got=%h:%h want=1004:deadbeef", last_wr_a, last_wr_d);
    end
  endtask

  task automatic test_fill;
    int lat, w0; logic [DW-1:0] rd; bit ok, seen;
    w0 = n_wr;
    stall = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b1, AW'(16'h1100 + 4 * i), $urandom, lat, rd);
      checks++;
      if (lat != 1) begin errors++; $display("FAIL fill_lat%0d got=%0d want=1", i, lat); end
    end
    checks += 2;
    if (up_ready !== 1'b0) begin errors++; $display("FAIL full_up_ready got=%b want=0", up_ready); end
    if (occupancy !== 4) begin errors++; $display("FAIL full_occ got=%0d want=4", occupancy); end
    // Hold a write request against a full buffer: it must not be taken.
    up_req = 1'b1; up_we = 1'b1; up_addr = 16'h1110; up_wdata = 32'h55555555;
    seen = 1'b0;
    repeat (3) begin @(negedge clk); seen |= up_done; end
    up_req = 1'b0;
    checks += 2;
    if (seen) begin errors++; $display("FAIL full_accept got=1 want=0"); end
    if (occupancy !== 4) begin errors++; $display("FAIL full_hold_occ got=%0d want=4", occupancy); end
    stall = 1'b0;
    xfer(1'b1, 16'h1110, 32'h55555555, lat, rd);
    wait_idle(ok);
    checks += 3;
    if (lat != 1) begin errors++; $display("FAIL fill5_lat got=%0d want=1", lat); end
    if (!ok || exp_wq.size() != 0) begin errors++; $display("FAIL fill_drain got=%0d want=0", exp_wq.size()); end
    if (n_wr - w0 != 5) begin errors++; $display("FAIL fill_count got=%0d want=5", n_wr - w0); end
  endtask

  task automatic test_raw;
    int lat, r0; logic [DW-1:0] rd; bit ok;
    r0 = n_rd;
    stall = 1'b1;
    repeat (2) @(negedge clk);
    xfer(1'b1, 16'h1004, 32'h11111111, lat, rd);
    xfer(1'b1, 16'h1004, 32'h22222222, lat, rd);
`ifdef WRITE_BUFFER_FWD_EN
    xfer(1'b0, 16'h1004, '0, lat, rd);
    checks += 3;
    if (lat != 1) begin errors++; $display("FAIL raw_fwd_lat got=%0d want=1", lat); end
    if (rd !== 32'h22222222) begin errors++; $display("FAIL raw_fwd_data got=%h want=22222222", rd); end
    if (n_rd != r0) begin errors++; $display("FAIL raw_fwd_memrd got=%0d want=0", n_rd - r0); end
    stall = 1'b0;
`else
    stall = 1'b0;
    xfer(1'b0, 16'h1004, '0, lat, rd);
    checks += 3;
    if (rd !== 32'h22222222) begin errors++; $display("FAIL raw_data got=%h want=22222222", rd); end
    if (n_rd - r0 != 1) begin errors++; $display("FAIL raw_memrd got=%0d want=1", n_rd - r0); end
    if (wq_at_read != 0) begin errors++; $display("FAIL raw_order got=%0d want=0", wq_at_read); end
`endif
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL raw_idle got=0 want=1"); end
  endtask

  task automatic test_read_empty;
    int lat, r0; logic [DW-1:0] rd, v;
    r0 = n_rd;
    v = $urandom;
    mem_arr[int'(16'h2000)] = v;
    xfer(1'b0, 16'h2000, '0, lat, rd);
    checks += 4;
    if (rd !== v) begin errors++; $display("FAIL rd_empty_data got=%h want=%h", rd, v); end
    if (n_rd - r0 != 1) begin errors++; $display("FAIL rd_empty_count got=%0d want=1", n_rd - r0); end
    if (last_rd_addr !== 16'h2000) begin errors++; $display("FAIL rd_empty_addr got=%h want=2000", last_rd_addr); end
    if (lat < 1 || lat > 10) begin errors++; $display("FAIL rd_empty_lat got=%0d want=1..10", lat); end
  endtask

  task automatic test_reset_mid;
    int lat, w; logic [DW-1:0] rd; bit sd, sr;
    stall = 1'b1;
    lat_fix = 6;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) xfer(1'b1, AW'(16'h4000 + 4 * i), $urandom, lat, rd);
    stall = 1'b0;
    w = 0;
    while (!busy && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    checks++;
    if (!busy) begin errors++; $display("FAIL rm_issue got=0 want=1"); end
    skip_hold = 1'b1;
    rst = 1'b0;
    #1;
    checks += 2;
    if (occupancy !== 0 || empty !== 1'b1) begin errors++; $display("FAIL rm_occ got=%0d want=0", occupancy); end
    if (mem_req !== 1'b0) begin errors++; $display("FAIL rm_mem_req got=%b want=0", mem_req); end
    @(negedge clk);
    rst = 1'b1;
    exp_wq.delete();
    sd = 1'b0; sr = 1'b0;
    repeat (12) begin @(negedge clk); sd |= up_done; sr |= mem_req; end
    checks += 2;
    if (sd) begin errors++; $display("FAIL rm_stale_done got=1 want=0"); end
    if (sr) begin errors++; $display("FAIL rm_stale_req got=1 want=0"); end
    lat_fix = 0;
    skip_hold = 1'b0;
  endtask

  task automatic test_random;
    int lat; logic [DW-1:0] rd, d; logic [AW-1:0] a; logic we; bit ok;
    for (int n = 0; n < 80; n++) begin
      we = ($urandom_range(0, 2) != 0);
      a  = AW'(16'h3000 + 4 * $urandom_range(0, 5));
      d  = $urandom;
      if (we) stall = ($urandom_range(0, 2) == 0) && (occupancy < 3);
      else    stall = 1'b0;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      if (we) begin
        xfer(1'b1, a, d, lat, rd);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL rnd_wr_lat n=%0d got=%0d want=1", n, lat); end
      end else begin
        d = ref_val(a);
        xfer(1'b0, a, '0, lat, rd);
        checks++;
        if (lat < 1 || rd !== d) begin
          errors++; $display("FAIL rnd_rd n=%0d addr=%h got=%h want=%h lat=%0d", n, a, rd, d, lat);
        end
      end
    end
    stall = 1'b0;
    wait_idle(ok);
    checks++;
    if (!ok || exp_wq.size() != 0) begin errors++; $display("FAIL rnd_final got=%0d want=0", exp_wq.size()); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_fill();
    test_raw();
    test_read_empty();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Posted-write FIFO between the write-through cache's memory port and main_memory.
- Absorbs cache write-throughs so the cache finishes writes in one cycle instead of waiting on memory latency.
- Drains buffered writes to memory in order and passes reads through.
- Reads are ordered behind all older writes, so read-after-write stays coherent.

Parameters:
DEPTH, 4, number of buffered write entries (power of 2, >=2)
AW, 16, address width
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
up_req  in  1  cache-side request pulse; sampled only when up_ready=1
up_we  in  1  1=write, 0=read; qualified by up_req
up_addr  in  AW  byte address
up_wdata  in  DW  write data
up_ready  out  1  buffer can accept a request this cycle
up_done  out  1  one-cycle completion pulse
up_rdata  out  DW  read data, valid while up_done=1
mem_req  out  1  memory request pulse
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address, held from mem_req until mem_done
mem_wdata  out  DW  memory write data, held from mem_req until mem_done
mem_ready  in  1  memory idle and able to accept
mem_done  in  1  memory completion pulse
mem_rdata  in  DW  memory read data, valid with mem_done
occupancy  out  $clog2(DEPTH)+1  number of buffered writes
empty  out  1  occupancy==0

Behaviour:
- Reset (rst=0, async):
  - FIFO pointers and count cleared; FSMs to IDLE.
  - up_done, up_rdata, mem_req, mem_we, mem_addr, mem_wdata are all 0; empty=1; occupancy=0.
  - up_ready=1 in the first cycle after rst deasserts.
  - Reset mid-transaction abandons the outstanding memory access; a stale mem_done arriving after reset is ignored.
- up_ready:
  - up_ready = !full && read FSM in R_IDLE.
  - Derived from registered state only; no combinational path from up_req.
- Write accept (up_req & up_we & up_ready):
  - {addr, wdata} pushed at the tail.
  - up_done pulses the next cycle; up_rdata unchanged.
- Drain FSM (D_IDLE, D_WAIT):
  - D_IDLE: when FIFO non-empty and mem_ready=1, pulse mem_req=1 and mem_we=1 for exactly 1 cycle, drive the head entry, go to D_WAIT.
  - D_WAIT: hold mem_addr/mem_wdata; on mem_done, pop the head, deassert mem_we, return to D_IDLE.
  - Next drain may issue the cycle after the pop if mem_ready=1.
- Read FSM (R_IDLE, R_DRAIN, R_ISSUE, R_WAIT, R_RESP):
  - R_IDLE: read accept (up_req & !up_we & up_ready) latches the address and goes to R_DRAIN (or R_RESP, see Optional Feature).
  - R_DRAIN: wait until the FIFO is empty and the drain FSM is in D_IDLE.
  - R_ISSUE: when mem_ready=1, pulse mem_req with mem_we=0, go to R_WAIT.
  - R_WAIT: on mem_done, capture mem_rdata into up_rdata and go to R_RESP.
  - R_RESP: up_done=1 for one cycle, then R_IDLE.
- Memory-port ownership:
  - Drain and read never issue in the same cycle; the read path issues only after the FIFO is empty.
- Simultaneous events:
  - Push and pop in the same cycle: occupancy unchanged.
  - Write accepted while full: impossible, since up_ready=0.
  - A pop in the cycle the FIFO is full raises up_ready the following cycle.
- Wrap-around: head/tail pointers wrap modulo DEPTH; full = (count==DEPTH).
- Addresses are used unmodified; no alignment checking.

Optional Feature:
- Macro: WRITE_BUFFER_FWD_EN.
- Defined:
  - On read accept, compare addr[AW-1:2] against all valid entries.
  - On a hit, go straight to R_RESP: up_done one cycle after accept, up_rdata = youngest matching entry, no memory read issued.
  - Drain continues unaffected.
  - On a miss, normal R_DRAIN path.
- Undefined: every read takes the R_DRAIN path; no comparators are synthesized.

Test Plan:
- Reset release: rst 0->1 -> up_ready=1, empty=1, mem_req=0, up_done=0.
- Single write 0x1004=DEADBEEF:
  - up_done one cycle after accept.
  - Exactly one mem_req with mem_we=1, addr 0x1004, data DEADBEEF; occupancy 1->0 on mem_done.
- Fill with 5 back-to-back writes, memory stalled (mem_ready=0):
  - First 4 accepted; up_ready=0 with occupancy=4.
  - After release, the 5th is accepted; memory receives writes in issue order.
- Read 0x1004 with writes 0x1004=11111111 then 0x1004=22222222 buffered:
  - Without the macro: both writes reach memory before the mem read; up_rdata=22222222.
  - With WRITE_BUFFER_FWD_EN: up_done one cycle after accept, up_rdata=22222222, no memory read.
- Read 0x2000 with an empty buffer: mem_req/mem_we=0 issued immediately; up_rdata equals memory content, delivered on up_done.
- Reset asserted while in D_WAIT with 3 entries: occupancy=0, mem_req=0; a later mem_done produces no up_done.
